// File: rtl/rrf_free_list.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rrf_free_list : retirement register file plus circular physical-register
//                 free list, with single-cycle restore on branch flush.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module rrf_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    commit_valid,
  input  logic [$clog2(NUM_AREGS)-1:0]            commit_rd,
  input  logic [$clog2(NUM_PREGS)-1:0]            commit_pd,
  input  logic                                    commit_regf_we,
  input  logic                                    alloc_req,
  output logic [$clog2(NUM_PREGS)-1:0]            alloc_preg,
  output logic                                    alloc_valid,
  input  logic                                    flush,
  output logic [NUM_AREGS*$clog2(NUM_PREGS)-1:0]  rrf_map,
  output logic [$clog2(NUM_PREGS-NUM_AREGS):0]    free_count
);

  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam int DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);

  logic [PREG_W-1:0] rrf  [NUM_AREGS];
  logic [PREG_W-1:0] ring [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic              commit_eff;
  logic [PTR_W-1:0]  tail_n;

  assign commit_eff  = commit_valid && commit_regf_we && (commit_rd != '0);
  assign tail_n      = tail + {{(PTR_W-1){1'b0}}, commit_eff};

  assign free_count  = tail - head;
  assign alloc_valid = (head != tail);
  assign alloc_preg  = ring[head[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        rrf[i] <= PREG_W'(i);
      end
      for (int j = 0; j < DEPTH; j++) begin
        ring[j] <= PREG_W'(NUM_AREGS + j);
      end
      head <= '0;
      tail <= FULL_COUNT;
    end else begin
      // The superseded mapping is read before this edge's rrf write lands.
      if (commit_eff) begin
        rrf[commit_rd]          <= commit_pd;
        ring[tail[IDX_W-1:0]]   <= rrf[commit_rd];
      end
      tail <= tail_n;
      // Flush makes the ring full relative to the post-commit tail.
      if (flush) begin
        head <= {~tail_n[PTR_W-1], tail_n[IDX_W-1:0]};
      end else if (alloc_req && alloc_valid) begin
        head <= head + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit_eff) begin
      assert (free_count != FULL_COUNT);
    end
  end

  for (genvar g = 0; g < NUM_AREGS; g++) begin : g_map
    assign rrf_map[g*PREG_W +: PREG_W] = rrf[g];
  end

endmodule
`default_nettype wire
